// File: rtl/obi_varlat_one_to_n_pkg.sv
// obi_varlat_one_to_n_pkg: OBI request/response bundles used by the 1-to-N demux.
package obi_varlat_one_to_n_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;
   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

// File: rtl/obi_varlat_one_to_n.sv
// obi_varlat_one_to_n: OBI 1-to-N demux; address-decoded requests, in-order responses,
// unmapped accesses answered locally with an error response one cycle after grant.
module obi_varlat_one_to_n
   import obi_varlat_one_to_n_pkg::*;
#(
   parameter int                       NSLAVE          = 2,
   parameter int                       MAX_OUTSTANDING = 4,
   parameter logic [NSLAVE-1:0][31:0]  SLAVE_BASE      = {32'h2000_0000, 32'h1000_0000},
   parameter logic [NSLAVE-1:0][31:0]  SLAVE_MASK      = {NSLAVE{32'hFFFF_0000}},
   parameter logic [31:0]              ERR_RDATA       = 32'hBADA_CCE5,
   localparam int                      CW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  obi_req_t              master_req_i,
   output obi_resp_t             master_resp_o,
   output obi_req_t [NSLAVE-1:0] slave_req_o,
   input  obi_resp_t [NSLAVE-1:0] slave_resp_i,
   output logic                  decode_err_o,
   output logic [CW-1:0]         outstanding_o
);
   localparam int TW = $clog2(NSLAVE + 1);
   localparam logic [TW-1:0] ERR = TW'(NSLAVE);
   logic [TW-1:0] tgt, last_tgt_d, last_tgt_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic          err_pend_d, err_pend_q;
   logic          is_err, stall, gnt, rvalid, sel_gnt, sel_rvalid;
   logic [31:0]   sel_rdata;
   // Lowest matching index wins, so iterate downwards and let later hits override.
   always_comb begin
      tgt = ERR;
      for (int i = NSLAVE - 1; i >= 0; i--)
         if ((master_req_i.addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) tgt = TW'(i);
   end
   always_comb begin
      sel_gnt    = 1'b0;
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      for (int i = 0; i < NSLAVE; i++) begin
         if (tgt == TW'(i)) sel_gnt = slave_resp_i[i].gnt;
         if (last_tgt_q == TW'(i)) begin
            sel_rvalid = slave_resp_i[i].rvalid;
            sel_rdata  = slave_resp_i[i].rdata;
         end
      end
   end
   // Switching targets waits for the pipe to drain so responses cannot overtake.
   assign is_err = tgt == ERR;
   assign stall  = cnt_q == CW'(MAX_OUTSTANDING) || (cnt_q != '0 && tgt != last_tgt_q);
   assign gnt    = master_req_i.req && !stall && (is_err || sel_gnt);
   assign rvalid = last_tgt_q == ERR ? err_pend_q : cnt_q != '0 && sel_rvalid;
   always_comb begin
      for (int i = 0; i < NSLAVE; i++) begin
         slave_req_o[i]     = master_req_i;
         slave_req_o[i].req = master_req_i.req && !stall && tgt == TW'(i);
      end
   end
   always_comb begin
      master_resp_o.gnt    = gnt;
      master_resp_o.rvalid = rvalid;
      master_resp_o.rdata  = !rvalid ? 32'h0 : last_tgt_q == ERR ? ERR_RDATA : sel_rdata;
      decode_err_o         = gnt && is_err;
      outstanding_o        = cnt_q;
      cnt_d                = cnt_q + CW'(gnt) - CW'(rvalid);
      err_pend_d           = (gnt && is_err) || (err_pend_q && !rvalid);
      last_tgt_d           = gnt ? tgt : last_tgt_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         err_pend_q <= 1'b0;
         last_tgt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         err_pend_q <= err_pend_d;
         last_tgt_q <= last_tgt_d;
      end
   end
endmodule

// File: tb/tb_obi_varlat_one_to_n.sv
// tb_obi_varlat_one_to_n: directed stimulus, per-cycle queue model plus literal spot checks.
module tb_obi_varlat_one_to_n;
   import obi_varlat_one_to_n_pkg::*;
   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   obi_req_t            mreq;
   obi_resp_t           mresp;
   obi_req_t  [1:0]     sreq;
   obi_resp_t [1:0]     sresp;
   logic                derr;
   logic [2:0]          outst;
   logic                s_gnt [2];
   logic                s_rv  [2];
   logic [31:0]         s_rd  [2];
   int                  total = 0;
   int                  bad = 0;
   int                  m_q [$];
   int                  m_last = 0;

   obi_varlat_one_to_n dut (
      .clk_i(clk), .rst_ni(rst_n), .master_req_i(mreq), .master_resp_o(mresp),
      .slave_req_o(sreq), .slave_resp_i(sresp), .decode_err_o(derr), .outstanding_o(outst)
   );

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < 2; i++) sresp[i] = '{gnt: s_gnt[i], rvalid: s_rv[i], rdata: s_rd[i]};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a queue of outstanding targets; 0/1 = slaves, 2 = unmapped.
   always @(negedge clk) begin
      int t;
      logic stl, e_gnt, e_rv;
      logic [31:0] e_rd;
      if (!rst_n) begin
         m_q.delete();
         m_last = 0;
      end
      t = mreq.addr[31:16] == 16'h1000 ? 0 : mreq.addr[31:16] == 16'h2000 ? 1 : 2;
      stl = m_q.size() == 4 || (m_q.size() != 0 && t != m_last);
      e_gnt = mreq.req && !stl && (t == 2 || s_gnt[t]);
      e_rv = 1'b0;
      e_rd = 32'h0;
      if (m_q.size() != 0) begin
         e_rv = m_last == 2 ? 1'b1 : s_rv[m_last];
         e_rd = !e_rv ? 32'h0 : m_last == 2 ? 32'hBADA_CCE5 : s_rd[m_last];
      end
      chk("m_gnt", {31'h0, mresp.gnt}, {31'h0, e_gnt});
      chk("m_rvalid", {31'h0, mresp.rvalid}, {31'h0, e_rv});
      chk("m_rdata", mresp.rdata, e_rd);
      chk("m_derr", {31'h0, derr}, {31'h0, e_gnt && t == 2});
      chk("m_outst", {29'h0, outst}, 32'(m_q.size()));
      chk("m_sreq0", {31'h0, sreq[0].req}, {31'h0, mreq.req && !stl && t == 0});
      chk("m_sreq1", {31'h0, sreq[1].req}, {31'h0, mreq.req && !stl && t == 1});
      chk("m_bcast", sreq[1].addr ^ {31'h0, sreq[0].we}, mreq.addr ^ {31'h0, mreq.we});
      if (rst_n) begin
         if (e_rv) void'(m_q.pop_front());
         if (e_gnt) begin
            m_q.push_back(t);
            m_last = t;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rq, input logic we, input logic [31:0] a);
      mreq.req = rq;
      mreq.we = we;
      mreq.addr = a;
      mreq.wdata = a ^ 32'h5A5A_0000;
      mreq.be = 4'hF;
   endtask

   initial begin
      drive(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         s_gnt[i] = 1'b0;
         s_rv[i] = 1'b0;
         s_rd[i] = 32'h0;
      end
      #2;
      chk("rst_outst", {29'h0, outst}, 32'd0);
      chk("rst_gnt", {31'h0, mresp.gnt}, 32'd0);
      chk("rst_rvalid", {31'h0, mresp.rvalid}, 32'd0);
      chk("rst_sreq", {30'h0, sreq[1].req, sreq[0].req}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      // Single read to slave 0, response two cycles after grant.
      s_gnt[0] = 1'b1;
      drive(1'b1, 1'b0, 32'h1000_0010);
      #1 chk("t1_sreq0", {31'h0, sreq[0].req}, 32'd1);
      chk("t1_sreq1", {31'h0, sreq[1].req}, 32'd0);
      chk("t1_gnt", {31'h0, mresp.gnt}, 32'd1);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      #1 chk("t1_out1", {29'h0, outst}, 32'd1);
      cyc();
      s_rv[0] = 1'b1;
      s_rd[0] = 32'hCAFE_0001;
      #1 chk("t1_rvalid", {31'h0, mresp.rvalid}, 32'd1);
      chk("t1_rdata", mresp.rdata, 32'hCAFE_0001);
      cyc();
      s_rv[0] = 1'b0;
      #1 chk("t1_out0", {29'h0, outst}, 32'd0);
      // Fill slave 1 to the outstanding limit.
      s_gnt[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 32'h2000_0000 + 32'(4 * k));
         #1 chk("t2_gnt", {31'h0, mresp.gnt}, 32'd1);
         cyc();
      end
      drive(1'b1, 1'b0, 32'h2000_0010);
      #1 chk("t2_stall_gnt", {31'h0, mresp.gnt}, 32'd0);
      chk("t2_out4", {29'h0, outst}, 32'd4);
      cyc();
      s_rv[1] = 1'b1;
      s_rd[1] = 32'hD000_0000;
      #1 chk("t2_gnt_rsp", {31'h0, mresp.gnt}, 32'd0);
      chk("t2_rd0", mresp.rdata, 32'hD000_0000);
      cyc();
      s_rv[1] = 1'b0;
      #1 chk("t2_out3", {29'h0, outst}, 32'd3);
      chk("t2_gnt5", {31'h0, mresp.gnt}, 32'd1);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      #1 chk("t2_out4b", {29'h0, outst}, 32'd4);
      for (int k = 1; k <= 4; k++) begin
         s_rv[1] = 1'b1;
         s_rd[1] = 32'hD000_0000 + 32'(k);
         #1 chk("t2_rd", mresp.rdata, 32'hD000_0000 + 32'(k));
         cyc();
      end
      s_rv[1] = 1'b0;
      #1 chk("t2_out0", {29'h0, outst}, 32'd0);
      // Slow slave 0 followed by fast slave 1: slave 1 must wait.
      drive(1'b1, 1'b0, 32'h1000_0100);
      #1 chk("t3_gnt0", {31'h0, mresp.gnt}, 32'd1);
      cyc();
      drive(1'b1, 1'b0, 32'h2000_0100);
      for (int k = 1; k < 10; k++) begin
         #1 chk("t3_hold", {31'h0, sreq[1].req}, 32'd0);
         cyc();
      end
      s_rv[0] = 1'b1;
      s_rd[0] = 32'hA000_0000;
      #1 chk("t3_rv0", mresp.rdata, 32'hA000_0000);
      chk("t3_hold_last", {31'h0, sreq[1].req}, 32'd0);
      cyc();
      s_rv[0] = 1'b0;
      #1 chk("t3_sreq1", {31'h0, sreq[1].req}, 32'd1);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      s_rv[1] = 1'b1;
      s_rd[1] = 32'hB000_0000;
      #1 chk("t3_rv1", mresp.rdata, 32'hB000_0000);
      cyc();
      s_rv[1] = 1'b0;
      // Unmapped write.
      drive(1'b1, 1'b1, 32'h3000_0000);
      #1 chk("t4_gnt", {31'h0, mresp.gnt}, 32'd1);
      chk("t4_derr", {31'h0, derr}, 32'd1);
      chk("t4_sreq", {30'h0, sreq[1].req, sreq[0].req}, 32'd0);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      #1 chk("t4_rvalid", {31'h0, mresp.rvalid}, 32'd1);
      chk("t4_rdata", mresp.rdata, 32'hBADA_CCE5);
      chk("t4_derr_off", {31'h0, derr}, 32'd0);
      cyc();
      #1 chk("t4_rv_off", {31'h0, mresp.rvalid}, 32'd0);
      // Grant and response in the same cycle at count 2.
      drive(1'b1, 1'b0, 32'h1000_0000);
      cyc();
      drive(1'b1, 1'b0, 32'h1000_0004);
      cyc();
      drive(1'b1, 1'b0, 32'h1000_0008);
      s_rv[0] = 1'b1;
      s_rd[0] = 32'h1111_0000;
      #1 chk("t5_gnt", {31'h0, mresp.gnt}, 32'd1);
      chk("t5_rv", {31'h0, mresp.rvalid}, 32'd1);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      #1 chk("t5_out2", {29'h0, outst}, 32'd2);
      cyc();
      cyc();
      s_rv[0] = 1'b0;
      #1 chk("t5_out0", {29'h0, outst}, 32'd0);
      drive(1'b1, 1'b0, 32'h1000_0000);
      cyc();
      drive(1'b0, 1'b0, 32'h0);
      s_rv[1] = 1'b1;
      s_rd[1] = 32'hDEAD_BEEF;
      #1 chk("t5_spur", {31'h0, mresp.rvalid}, 32'd0);
      cyc();
      s_rv[1] = 1'b0;
      s_rv[0] = 1'b1;
      #1 chk("t5_real", {31'h0, mresp.rvalid}, 32'd1);
      cyc();
      s_rv[0] = 1'b0;
      // Reset with three outstanding, then a late response.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 32'h1000_0000 + 32'(4 * k));
         cyc();
      end
      drive(1'b0, 1'b0, 32'h0);
      #1 chk("t6_out3", {29'h0, outst}, 32'd3);
      rst_n = 1'b0;
      #1 chk("t6_async", {29'h0, outst}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      s_rv[0] = 1'b1;
      s_rd[0] = 32'h7777_7777;
      #1 chk("t6_late", {31'h0, mresp.rvalid}, 32'd0);
      cyc();
      s_rv[0] = 1'b0;
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
